// File: rtl/word_unpack16.sv
// rtl/word_unpack16.sv - splits each accepted 16-bit word into two output bytes
// Outputs are registered alongside the state so nothing downstream sees in_data combinationally.
module word_unpack16 #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND
    } stateType;

    stateType    state;
    logic [15:0] holdWord;
    logic        wordAccept;
    logic        byteXfer;

    function automatic logic [7:0] firstByte(input logic [15:0] w);
        return HIGH_FIRST ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [7:0] secondByte(input logic [15:0] w);
        return HIGH_FIRST ? w[7:0] : w[15:8];
    endfunction

    // A new word may slip in while the last byte of the previous one leaves.
    assign in_ready   = !reset && ((state == IDLE) || ((state == SECOND) && out_ready));
    assign wordAccept = in_valid && in_ready;
    assign byteXfer   = out_valid && out_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            holdWord  <= 16'h0000;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wordAccept) begin
                        holdWord  <= in_data;
                        state     <= FIRST;
                        out_valid <= 1'b1;
                        out_data  <= firstByte(in_data);
                        out_last  <= 1'b0;
                    end
                end
                FIRST: begin
                    if (byteXfer) begin
                        state    <= SECOND;
                        out_data <= secondByte(holdWord);
                        out_last <= 1'b1;
                    end
                end
                SECOND: begin
                    if (byteXfer) begin
                        if (wordAccept) begin
                            holdWord  <= in_data;
                            state     <= FIRST;
                            out_valid <= 1'b1;
                            out_data  <= firstByte(in_data);
                            out_last  <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_data  <= 8'h00;
                            out_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_data  <= 8'h00;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_unpack16.sv
// tb/tb_word_unpack16.sv - self-checking bench for word_unpack16 in both byte orders
module tb_word_unpack16;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        hiInReady, hiOutValid, hiOutLast, hiBusy;
    logic [7:0]  hiOutData;
    logic        loInReady, loOutValid, loOutLast, loBusy;
    logic [7:0]  loOutData;

    int checks = 0;
    int errors = 0;

    // Expected output stream per instance: {last, byte}, head is what is presented now.
    logic [8:0] qHi[$];
    logic [8:0] qLo[$];

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        eRdy;
        logic        eValid;
        logic [7:0]  eData;
        logic        eLast;
        logic        eBusy;
    } vecType;

    vecType tbl[$];

    word_unpack16 #(.HIGH_FIRST(1'b1)) uHi (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(hiInReady), .out_valid(hiOutValid), .out_data(hiOutData),
        .out_last(hiOutLast), .out_ready(out_ready), .busy(hiBusy)
    );

    word_unpack16 #(.HIGH_FIRST(1'b0)) uLo (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(loInReady), .out_valid(loOutValid), .out_data(loOutData),
        .out_last(loOutLast), .out_ready(out_ready), .busy(loBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] expVec(input int n, input logic [8:0] head);
        logic rdy;
        rdy = !reset && ((n == 0) || ((n == 1) && out_ready));
        return {rdy, (n > 0), (n > 0) ? head[7:0] : 8'h00, (n > 0) ? head[8] : 1'b0, (n > 0)};
    endfunction

    function automatic logic [11:0] expHi();
        return expVec(qHi.size(), (qHi.size() > 0) ? qHi[0] : 9'h000);
    endfunction

    function automatic logic [11:0] expLo();
        return expVec(qLo.size(), (qLo.size() > 0) ? qLo[0] : 9'h000);
    endfunction

    task automatic checkVec(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {rdy,vld,data,last,busy}=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advances the reference queues by the handshakes that happen at the coming edge.
    task automatic modelEdge();
        logic hiXfer, loXfer, hiAcc, loAcc;
        hiXfer = (qHi.size() > 0) && out_ready;
        loXfer = (qLo.size() > 0) && out_ready;
        hiAcc  = in_valid && !reset && ((qHi.size() == 0) || ((qHi.size() == 1) && out_ready));
        loAcc  = in_valid && !reset && ((qLo.size() == 0) || ((qLo.size() == 1) && out_ready));
        if (reset) begin
            qHi.delete();
            qLo.delete();
        end else begin
            if (hiXfer) void'(qHi.pop_front());
            if (loXfer) void'(qLo.pop_front());
            if (hiAcc) begin
                qHi.push_back({1'b0, in_data[15:8]});
                qHi.push_back({1'b1, in_data[7:0]});
            end
            if (loAcc) begin
                qLo.push_back({1'b0, in_data[7:0]});
                qLo.push_back({1'b1, in_data[15:8]});
            end
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [15:0] d, input logic o);
        reset     = r;
        in_valid  = v;
        in_data   = d;
        out_ready = o;
        @(negedge clk);
    endtask

    task automatic finishCycle();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
        @(posedge clk);
        #1;

        //                 rst   iv    id        ordy  rdy   vld   data   last  busy
        tbl.push_back({1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back({1'b0, 1'b1, 16'hA55A, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back({1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1});
        tbl.push_back({1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b1, 16'h0102, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back({1'b0, 1'b1, 16'h0304, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1});
        tbl.push_back({1'b0, 1'b1, 16'h0304, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b1, 16'h0506, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1});
        tbl.push_back({1'b0, 1'b1, 16'h0506, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 1'b1});
        tbl.push_back({1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h06, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back({1'b0, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b1, 8'hBE, 1'b0, 1'b1});
        tbl.push_back({1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 8'hBE, 1'b0, 1'b1});
        tbl.push_back({1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 8'hBE, 1'b0, 1'b1});
        tbl.push_back({1'b0, 1'b1, 16'h4444, 1'b1, 1'b0, 1'b1, 8'hBE, 1'b0, 1'b1});
        tbl.push_back({1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 8'hEF, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b1, 16'h6666, 1'b0, 1'b0, 1'b1, 8'hEF, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hEF, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b1, 16'hCAFE, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back({1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'hCA, 1'b0, 1'b1});
        tbl.push_back({1'b1, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back({1'b0, 1'b1, 16'h0011, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back({1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1});
        tbl.push_back({1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            checkVec($sformatf("tbl_hi[%0d]", i),
                     {hiInReady, hiOutValid, hiOutData, hiOutLast, hiBusy},
                     {tbl[i].eRdy, tbl[i].eValid, tbl[i].eData, tbl[i].eLast, tbl[i].eBusy});
            checkVec($sformatf("tbl_lo[%0d]", i),
                     {loInReady, loOutValid, loOutData, loOutLast, loBusy}, expLo());
            finishCycle();
        end

        // Reset held for several cycles with a word offered: nothing may be taken.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'h7777, 1'b1);
            checkVec("rst_hold_hi", {hiInReady, hiOutValid, hiOutData, hiOutLast, hiBusy}, 12'h000);
            checkVec("rst_hold_lo", {loInReady, loOutValid, loOutData, loOutLast, loBusy}, 12'h000);
            finishCycle();
        end

        // Low-byte-first order on 0x1234.
        drive(1'b0, 1'b1, 16'h1234, 1'b1);
        checkVec("lo_1234_idle", {loInReady, loOutValid, loOutData, loOutLast, loBusy}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        finishCycle();
        drive(1'b0, 1'b0, 16'hFFFF, 1'b1);
        checkVec("lo_1234_b0", {loInReady, loOutValid, loOutData, loOutLast, loBusy}, {1'b0, 1'b1, 8'h34, 1'b0, 1'b1});
        checkVec("hi_1234_b0", {hiInReady, hiOutValid, hiOutData, hiOutLast, hiBusy}, {1'b0, 1'b1, 8'h12, 1'b0, 1'b1});
        finishCycle();
        drive(1'b0, 1'b0, 16'hFFFF, 1'b1);
        checkVec("lo_1234_b1", {loInReady, loOutValid, loOutData, loOutLast, loBusy}, {1'b1, 1'b1, 8'h12, 1'b1, 1'b1});
        checkVec("hi_1234_b1", {hiInReady, hiOutValid, hiOutData, hiOutLast, hiBusy}, {1'b1, 1'b1, 8'h34, 1'b1, 1'b1});
        finishCycle();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checkVec("lo_1234_done", {loInReady, loOutValid, loOutData, loOutLast, loBusy}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        finishCycle();

        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  16'($urandom), ($urandom_range(0, 3) != 0));
            checkVec("rand_hi", {hiInReady, hiOutValid, hiOutData, hiOutLast, hiBusy}, expHi());
            checkVec("rand_lo", {loInReady, loOutValid, loOutData, loOutLast, loBusy}, expLo());
            finishCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
